// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin front end that shares the UART status/data
// register pair between two requesters. Every accepted request produces
// exactly one single-cycle strobe on the UART bus, optionally preceded by
// bounded polling of the status register.
//
// state  | meaning
// IDLE   | bus idle, arbitrating between m0_req and m1_req
// POLL   | reading STATE_ADDR until the needed ready bit is set
// ACCESS | single-cycle data strobe to the latched address
// RESP   | result ready; owner's ack pulses on the following cycle
module uart_bus_arbiter #(
    parameter logic [31:0] STATE_ADDR = 32'hBFD003FC,
    parameter logic [31:0] DATA_ADDR  = 32'hBFD003F8,
    parameter bit          POLL_TX    = 1'b1,
    parameter bit          POLL_RX    = 1'b1,
    parameter int          POLL_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_data,
    output logic        slv_oe_n,
    output logic        slv_we_n,
    input  logic [31:0] slv_rdata,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_POLL   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(POLL_LIMIT - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        owner;
    logic        last;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic [15:0] poll_cnt;

    logic        req_any;
    logic        pick;
    logic        pick_we;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;
    logic        pick_poll;
    logic        status_ok;
    logic        poll_last;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_we;

    // On a tie the requester that did not finish last wins.
    assign req_any    = m0_req | m1_req;
    assign pick       = (m0_req & m1_req) ? ~last : m1_req;
    assign pick_we    = pick ? m1_we    : m0_we;
    assign pick_addr  = pick ? m1_addr  : m0_addr;
    assign pick_wdata = pick ? m1_wdata : m0_wdata;
    assign pick_poll  = (pick_addr == DATA_ADDR) && (pick_we ? POLL_TX : POLL_RX);
    assign status_ok  = we_q ? slv_rdata[0] : slv_rdata[1];
    assign poll_last  = (poll_cnt == CNT_LAST);

    // An ACCESS entered straight from IDLE uses the request being granted.
    assign acc_addr  = (state == S_IDLE) ? pick_addr  : addr_q;
    assign acc_wdata = (state == S_IDLE) ? pick_wdata : wdata_q;
    assign acc_we    = (state == S_IDLE) ? pick_we    : we_q;

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_any) state_nxt = pick_poll ? S_POLL : S_ACCESS;
            S_POLL: begin
                if (status_ok)      state_nxt = S_ACCESS;
                else if (poll_last) state_nxt = S_RESP;
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, transaction latches and registered outputs; bus outputs are
    // computed for the state being entered so they line up with that state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            poll_cnt <= '0;
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
            slv_addr <= '0;
            slv_data <= '0;
            slv_oe_n <= 1'b1;
            slv_we_n <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy   <= (state_nxt != S_IDLE);
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        owner    <= pick;
                        we_q     <= pick_we;
                        addr_q   <= pick_addr;
                        wdata_q  <= pick_wdata;
                        poll_cnt <= '0;
                        rd_q     <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_POLL: begin
                    if (!status_ok) begin
                        if (poll_last) err_q    <= 1'b1;
                        else           poll_cnt <= poll_cnt + 16'd1;
                    end
                end
                S_ACCESS: begin
                    rd_q  <= we_q ? 32'h0 : slv_rdata;
                    err_q <= 1'b0;
                end
                S_RESP: begin
                    last <= owner;
                    if (owner) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= rd_q;
                        m1_err   <= err_q;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= rd_q;
                        m0_err   <= err_q;
                    end
                end
                default: ;
            endcase

            // Idle bus uses address 0, which never matches a UART register.
            slv_addr <= '0;
            slv_data <= '0;
            slv_oe_n <= 1'b1;
            slv_we_n <= 1'b1;
            if (state_nxt == S_POLL) begin
                slv_addr <= STATE_ADDR;
                slv_oe_n <= 1'b0;
            end else if (state_nxt == S_ACCESS) begin
                slv_addr <= acc_addr;
                slv_data <= acc_wdata;
                slv_we_n <= ~acc_we;
                slv_oe_n <= acc_we;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Testbench for uart_bus_arbiter: directed scenarios plus randomized single
// transactions checked against a transaction-level expectation model.
module tb_uart_bus_arbiter;

    localparam logic [31:0] STATE_ADDR = 32'hBFD003FC;
    localparam logic [31:0] DATA_ADDR  = 32'hBFD003F8;
    localparam logic [31:0] OTHER_ADDR = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] slv_addr, slv_data, slv_rdata;
    logic        slv_oe_n, slv_we_n, busy;

    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic [31:0] b_slv_addr, b_slv_data, b_slv_rdata;
    logic        b_slv_oe_n, b_slv_we_n, b_busy;

    int checks   = 0;
    int failures = 0;

    // Slave model: status turns ready after fails_cfg status reads.
    int          st_total  = 0;
    int          st_base   = 0;
    int          fails_cfg = 0;
    logic [29:0] stat_hi   = '0;
    logic [31:0] dval      = '0;
    logic        st_ready;

    int          mon_st = 0, mon_rd = 0, mon_wr = 0, mon_both = 0, mon_idle_bad = 0;
    int          mon_a0 = 0, mon_a1 = 0;
    logic [31:0] mon_wdata = '0, mon_waddr = '0;
    int          b_st = 0, b_rd = 0, b_wr = 0, b_a0 = 0, b_a1 = 0;

    always #5 clk = ~clk;

    assign st_ready  = (st_total - st_base) >= fails_cfg;
    assign slv_rdata = (slv_addr == STATE_ADDR) ? {stat_hi, st_ready, st_ready} :
                       (slv_addr == DATA_ADDR)  ? dval : 32'h0;
    assign b_slv_rdata = 32'h0;

    uart_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .slv_addr(slv_addr), .slv_data(slv_data), .slv_oe_n(slv_oe_n),
        .slv_we_n(slv_we_n), .slv_rdata(slv_rdata), .busy(busy)
    );

    uart_bus_arbiter #(.POLL_LIMIT(4)) dut_lim (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .slv_addr(b_slv_addr), .slv_data(b_slv_data), .slv_oe_n(b_slv_oe_n),
        .slv_we_n(b_slv_we_n), .slv_rdata(b_slv_rdata), .busy(b_busy)
    );

    always @(posedge clk) begin
        if (!slv_oe_n && slv_addr == STATE_ADDR) st_total <= st_total + 1;
    end

    always @(negedge clk) begin
        if (!slv_oe_n && slv_addr == STATE_ADDR) mon_st <= mon_st + 1;
        if (!slv_oe_n && slv_addr != STATE_ADDR) mon_rd <= mon_rd + 1;
        if (!slv_we_n) begin
            mon_wr    <= mon_wr + 1;
            mon_wdata <= slv_data;
            mon_waddr <= slv_addr;
        end
        if (!slv_oe_n && !slv_we_n) mon_both <= mon_both + 1;
        if (slv_oe_n && slv_we_n && (slv_addr != 32'h0 || slv_data != 32'h0))
            mon_idle_bad <= mon_idle_bad + 1;
        if (m0_ack) mon_a0 <= mon_a0 + 1;
        if (m1_ack) mon_a1 <= mon_a1 + 1;
        if (!b_slv_oe_n && b_slv_addr == STATE_ADDR) b_st <= b_st + 1;
        if (!b_slv_oe_n && b_slv_addr != STATE_ADDR) b_rd <= b_rd + 1;
        if (!b_slv_we_n) b_wr <= b_wr + 1;
        if (b_m0_ack) b_a0 <= b_a0 + 1;
        if (b_m1_ack) b_a1 <= b_a1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit who, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (who) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // One transaction on the main instance, started from an idle negedge.
    task automatic do_txn(input bit who, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int fails, input string tag);
        int          n;
        bit          got;
        int          exp_polls;
        int          exp_st;
        logic [31:0] exp_rd;
        int          s_st, s_rd, s_wr, s_a0, s_a1;

        exp_polls = (addr == DATA_ADDR) ? fails + 1 : 0;
        exp_st    = exp_polls + ((!we && addr == STATE_ADDR) ? 1 : 0);
        if (we)                      exp_rd = 32'h0;
        else if (addr == DATA_ADDR)  exp_rd = dval;
        else if (addr == STATE_ADDR) exp_rd = {stat_hi, {2{fails == 0}}};
        else                         exp_rd = 32'h0;

        fails_cfg = fails;
        st_base   = st_total;
        s_st = mon_st; s_rd = mon_rd; s_wr = mon_wr; s_a0 = mon_a0; s_a1 = mon_a1;

        drive(who, 1'b1, we, addr, wdata);
        @(posedge clk);
        #1 drive(who, 1'b1, ~we, $urandom, $urandom);
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) check({tag, " busy"}, busy, 1);
            got = who ? m1_ack : m0_ack;
        end
        check({tag, " latency"}, n, exp_polls + 2);
        check({tag, " rdata"}, who ? m1_rdata : m0_rdata, exp_rd);
        check({tag, " err"}, who ? m1_err : m0_err, 0);
        check({tag, " other_ack"}, who ? m0_ack : m1_ack, 0);
        check({tag, " idle_busy"}, busy, 0);
        drive(who, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check({tag, " status_reads"}, mon_st - s_st, exp_st);
        check({tag, " write_strobes"}, mon_wr - s_wr, we ? 1 : 0);
        check({tag, " data_reads"}, mon_rd - s_rd, (!we && addr != STATE_ADDR) ? 1 : 0);
        if (we) begin
            check({tag, " wr_addr"}, mon_waddr, addr);
            check({tag, " wr_data"}, mon_wdata, wdata);
        end
        check({tag, " own_acks"}, who ? mon_a1 - s_a1 : mon_a0 - s_a0, 1);
        check({tag, " foreign_acks"}, who ? mon_a0 - s_a0 : mon_a1 - s_a1, 0);
    endtask

    // Timeout transaction on the POLL_LIMIT=4 instance, whose status never readies.
    task automatic b_txn(input bit who, input bit we, input string tag);
        int n;
        bit got;
        int s_st, s_rd, s_wr, s_a0, s_a1;
        s_st = b_st; s_rd = b_rd; s_wr = b_wr; s_a0 = b_a0; s_a1 = b_a1;
        if (who) begin
            b_m1_req = 1'b1; b_m1_we = we; b_m1_addr = DATA_ADDR; b_m1_wdata = 32'h77;
        end else begin
            b_m0_req = 1'b1; b_m0_we = we; b_m0_addr = DATA_ADDR; b_m0_wdata = 32'h77;
        end
        @(posedge clk);
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = who ? b_m1_ack : b_m0_ack;
        end
        check({tag, " latency"}, n, 5);
        check({tag, " err"}, who ? b_m1_err : b_m0_err, 1);
        check({tag, " rdata"}, who ? b_m1_rdata : b_m0_rdata, 0);
        b_m0_req = 1'b0;
        b_m1_req = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, " polls"}, b_st - s_st, 4);
        check({tag, " write_strobes"}, b_wr - s_wr, 0);
        check({tag, " data_reads"}, b_rd - s_rd, 0);
        check({tag, " own_acks"}, who ? b_a1 - s_a1 : b_a0 - s_a0, 1);
        check({tag, " foreign_acks"}, who ? b_a0 - s_a0 : b_a1 - s_a1, 0);
    endtask

    initial begin
        bit          r_who, r_we;
        int          r_sel, r_fails;
        logic [31:0] r_addr;
        int          s_a1;
        int          cnt, cyc, prev_cyc;

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
        repeat (3) @(negedge clk);

        check("rst m0_ack", m0_ack, 0);
        check("rst m1_ack", m1_ack, 0);
        check("rst m0_err", m0_err, 0);
        check("rst m1_err", m1_err, 0);
        check("rst m0_rdata", m0_rdata, 0);
        check("rst m1_rdata", m1_rdata, 0);
        check("rst busy", busy, 0);
        check("rst slv_addr", slv_addr, 0);
        check("rst slv_data", slv_data, 0);
        check("rst slv_oe_n", slv_oe_n, 1);
        check("rst slv_we_n", slv_we_n, 1);
        check("rst lim busy", b_busy, 0);
        rst = 1'b1;
        @(negedge clk);

        stat_hi = '0;
        do_txn(1'b0, 1'b1, DATA_ADDR, 32'h41, 0, "m0_wr_data");
        dval = 32'h5A;
        do_txn(1'b1, 1'b0, DATA_ADDR, 32'h0, 5, "m1_rd_data");
        stat_hi = 30'h2A;
        do_txn(1'b0, 1'b0, STATE_ADDR, 32'h0, 0, "m0_rd_state");
        b_txn(1'b0, 1'b1, "lim_wr");
        b_txn(1'b1, 1'b0, "lim_rd");

        for (int i = 0; i < 24; i++) begin
            r_who   = 1'($urandom_range(0, 1));
            r_we    = 1'($urandom_range(0, 1));
            r_sel   = int'($urandom_range(0, 2));
            r_fails = int'($urandom_range(0, 6));
            r_addr  = (r_sel == 0) ? DATA_ADDR :
                      (r_sel == 1) ? STATE_ADDR : (32'h8000_0000 | ($urandom & 32'h0FFF_FFFC));
            stat_hi = 30'($urandom);
            dval    = $urandom;
            do_txn(r_who, r_we, r_addr, $urandom, r_fails, $sformatf("rnd%0d", i));
        end

        // Reset while m1 is polling; m0 finished last, so reset must restore last=1.
        do_txn(1'b0, 1'b1, OTHER_ADDR, 32'h11, 0, "pre_rst");
        fails_cfg = 50;
        st_base   = st_total;
        s_a1      = mon_a1;
        drive(1'b1, 1'b1, 1'b0, DATA_ADDR, 32'h0);
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("mid_rst polling", slv_oe_n, 0);
        check("mid_rst poll_addr", slv_addr, STATE_ADDR);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst busy", busy, 0);
        check("mid_rst ack", m1_ack, 0);
        check("mid_rst slv_addr", slv_addr, 0);
        check("mid_rst slv_oe_n", slv_oe_n, 1);
        check("mid_rst slv_we_n", slv_we_n, 1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst no_ack", mon_a1 - s_a1, 0);
        check("mid_rst idle", busy, 0);

        // Both requesters held continuously: m0 first, then strict alternation.
        drive(1'b0, 1'b1, 1'b1, OTHER_ADDR, 32'h22);
        drive(1'b1, 1'b1, 1'b0, OTHER_ADDR, 32'h0);
        cnt = 0;
        cyc = 0;
        prev_cyc = 0;
        while (cnt < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m0_ack || m1_ack) begin
                check("rr single_ack", m0_ack & m1_ack, 0);
                check($sformatf("rr owner%0d", cnt), m1_ack, cnt % 2);
                if (cnt > 0) check("rr spacing", cyc - prev_cyc, 3);
                prev_cyc = cyc;
                cnt++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rr ack_count", cnt, 4);
        repeat (3) @(negedge clk);
        check("bus idle_values", mon_idle_bad, 0);
        check("bus both_strobes", mon_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Shares the memory-mapped UART register pair (status 0xBFD003FC, data 0xBFD003F8) between two requesters: m0 is the CPU data port and m1 is the boot/debug loader.
- Each accepted request becomes exactly one single-cycle strobe on the UART bus. A held address can therefore never cause repeated FIFO pushes or pops.
- Optionally polls the status register before a data access until the UART is ready, and aborts with an error after a bounded number of polls.

Parameters:
- STATE_ADDR, 32'hBFD003FC, UART status register address.
- DATA_ADDR, 32'hBFD003F8, UART data register address.
- POLL_TX, 1, poll status bit0 (TX not full) before a write to DATA_ADDR.
- POLL_RX, 1, poll status bit1 (RX valid) before a read from DATA_ADDR.
- POLL_LIMIT, 4096, maximum status polls before abort; range 1..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low: sampled on rising clk, asserted when 0.
- m0_req  in  1  requester 0 request; held high until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  target address.
- m0_wdata  in  32  write data; only bits [7:0] are meaningful.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  32  read data; valid while m0_ack is high.
- m0_err  out  1  poll timeout; valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: identical to the m0 set, for requester 1.
- slv_addr  out  32  UART bus address.
- slv_data  out  32  UART bus write data.
- slv_oe_n  out  1  UART read enable, active-low.
- slv_we_n  out  1  UART write enable, active-low.
- slv_rdata  in  32  UART read data, combinational from slv_addr.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - State = IDLE, poll_cnt = 0, last = 1 (so m0 wins the first tie).
  - All acks and errs = 0; rdata outputs = 0; busy = 0.
  - UART bus is idle: slv_addr = 0, slv_data = 0, slv_oe_n = 1, slv_we_n = 1.
- Idle bus: in every state except POLL and ACCESS the bus stays at the idle values. Address 0 must never decode as a UART register.
- IDLE:
  - Arbitration: if exactly one req is high, grant it. If both are high, grant the requester that is not `last` (round-robin).
  - On grant, latch owner, we, addr and wdata.
  - Next state is POLL if (we && addr == DATA_ADDR && POLL_TX) or (!we && addr == DATA_ADDR && POLL_RX); otherwise ACCESS.
  - poll_cnt is cleared on grant.
- POLL:
  - Bus drives slv_addr = STATE_ADDR, slv_oe_n = 0, slv_we_n = 1.
  - The required bit is slv_rdata[0] for a write and slv_rdata[1] for a read.
  - If the bit is 1, go to ACCESS.
  - Else if poll_cnt == POLL_LIMIT-1, latch err = 1 and go to RESP without any data access.
  - Else increment poll_cnt and stay in POLL.
- ACCESS: lasts exactly one cycle.
  - slv_addr = latched addr; slv_data = latched wdata.
  - slv_we_n = !we; slv_oe_n = we.
  - For a read, capture slv_rdata into the read register. For a write, the read register is 0. Set err = 0.
  - Go to RESP.
- RESP:
  - Pulse the owner's ack for one cycle, with rdata and err valid. The other requester's ack stays 0.
  - Set last = owner and go to IDLE.
- Request protocol:
  - A req still high in the IDLE cycle after its ack is a new request.
  - Dropping req mid-transaction does not cancel the transaction; the ack still pulses.
  - Input changes after grant are ignored.
- Latency, counted from the IDLE clock edge that grants:
  - Non-polled access: ack high 2 cycles later.
  - Polled access that succeeds on the k-th poll: ack high k+2 cycles later.
  - Timeout: ack with err high POLL_LIMIT+1 cycles later.
- Back-to-back: minimum spacing between grants is 3 cycles (IDLE, ACCESS, RESP). A requester held waiting is guaranteed a grant after at most one transaction by the other requester.
- Accesses to other addresses pass through without polling; the slave returns 0 for them.
- Reset mid-operation: the in-flight transaction is dropped with no ack, and the bus returns to idle on the same edge.

Test Plan:
- m0 writes 0x41 to DATA_ADDR; slv_rdata = 0x1 on STATE_ADDR. Required: one POLL cycle, then one ACCESS cycle with slv_we_n = 0 and slv_data = 0x41; m0_ack 3 cycles after grant with m0_err = 0; the write strobe is exactly 1 cycle wide.
- m1 reads DATA_ADDR; status bit1 = 0 for 5 polls, then 1; data = 0x5A. Required: 6 POLL cycles, then ACCESS; m1_ack with m1_rdata = 0x0000005A, 8 cycles after grant.
- Both req high, held continuously. Required: grant order m0, m1, m0, m1; each ack is seen only by its owner.
- POLL_LIMIT = 4 and status stays 0 during a write. Required: 4 POLL cycles and no ACCESS (slv_we_n stays 1); ack with err = 1, 5 cycles after grant.
- m0 reads STATE_ADDR. Required: no POLL; single ACCESS with slv_oe_n = 0; m0_ack after 2 cycles with rdata equal to the status value.
- rst driven low during POLL. Required: on the next edge state = IDLE, busy = 0, no ack, bus idle, last = 1. The next simultaneous request grants m0.
